// File: rtl/barcode_pkg.sv
// Shared types and constants for the IR barcode receiver.
package barcode_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        WAIT_EDGE,
        SAMPLE,
        CHECK,
        HOLD
    } bc_state_t;

    localparam int SYNC_DEPTH = 2;
    // TO_MULT must fit in this many bits; the timeout limit is CNT_W+TO_MULT_W wide.
    localparam int TO_MULT_W  = 4;

endpackage

// File: rtl/bc_sync_edge.sv
// Synchroniser for the asynchronous IR input plus falling-edge detect.
// Everything presets to 1 so that the idle-high line never produces a spurious edge.
module bc_sync_edge
    import barcode_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bc,
    output logic sync,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_ff;
    logic                  prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '1;
            prev    <= 1'b1;
        end else begin
            sync_ff <= {sync_ff[SYNC_DEPTH-2:0], bc};
            prev    <= sync_ff[SYNC_DEPTH-1];
        end
    end

    assign sync = sync_ff[SYNC_DEPTH-1];
    assign fall = prev & ~sync;

endmodule

// File: rtl/barcode_rx.sv
// IR barcode frame decoder: start bit sets the half period, then ID_W data bits
// (MSB first) and an optional even-parity bit are sampled mid-bit.
module barcode_rx
    import barcode_pkg::*;
#(
    parameter int ID_W      = 8,
    parameter int PREFIX_W  = 2,
    parameter int CNT_W     = 22,
    parameter int PARITY_EN = 0,
    parameter int TO_MULT   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            BC,
    input  logic            clr_ID_vld,
    output logic            ID_vld,
    output logic [ID_W-1:0] ID,
    output logic            err,
    output logic            busy
);

    localparam int TO_W  = CNT_W + TO_MULT_W;
    localparam int NBITS = ID_W + PARITY_EN;
    localparam int BIT_W = $clog2(NBITS + 1);

    localparam logic [ID_W-1:0]  PREFIX_MASK = ~({ID_W{1'b1}} >> PREFIX_W);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(NBITS - 1);
    localparam logic [BIT_W-1:0] PAR_IDX     = BIT_W'(ID_W);

    bc_state_t        state;
    bc_state_t        state_nxt;
    logic             sync;
    logic             fall;
    logic [CNT_W-1:0] half_cnt;
    logic [CNT_W-1:0] sample_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_limit;
    logic [BIT_W-1:0] bit_cnt;
    logic             parity;
    logic             half_max;
    logic             sample_hit;
    logic             timed_out;
    logic             frame_bad;

    bc_sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .bc    (BC),
        .sync  (sync),
        .fall  (fall)
    );

    assign to_limit   = TO_W'(half_cnt) * TO_W'(TO_MULT);
    assign half_max   = &half_cnt;
    // The sample lands half_cnt cycles after the synchronised edge; SAMPLE starts one cycle after it.
    assign sample_hit = (sample_cnt + CNT_W'(1)) == half_cnt;
    assign timed_out  = to_cnt == to_limit;
    assign frame_bad  = (|(ID & PREFIX_MASK)) | ((PARITY_EN != 0) && ((^ID) ^ parity));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fall) state_nxt = MEASURE;
            MEASURE: begin
                if (sync)          state_nxt = WAIT_EDGE;
                else if (half_max) state_nxt = IDLE;
            end
            WAIT_EDGE: begin
                if (fall)           state_nxt = SAMPLE;
                else if (timed_out) state_nxt = IDLE;
            end
            SAMPLE: begin
                if (sample_hit) state_nxt = (bit_cnt == LAST_BIT) ? CHECK : WAIT_EDGE;
            end
            CHECK:     state_nxt = frame_bad ? IDLE : HOLD;
            HOLD:      if (clr_ID_vld) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        err  = 1'b0;
        busy = 1'b0;
        case (state)
            MEASURE: begin
                busy = 1'b1;
                err  = ~sync & half_max;
            end
            WAIT_EDGE: begin
                busy = 1'b1;
                err  = ~fall & timed_out;
            end
            SAMPLE:  busy = 1'b1;
            CHECK:   err  = frame_bad;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_cnt   <= '0;
            sample_cnt <= '0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            parity     <= 1'b0;
            ID         <= '0;
            ID_vld     <= 1'b0;
        end else begin
            if (clr_ID_vld) ID_vld <= 1'b0;
            case (state)
                IDLE: if (fall) half_cnt <= CNT_W'(1);
                MEASURE: begin
                    if (sync) begin
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                    end else if (!half_max) begin
                        half_cnt <= half_cnt + CNT_W'(1);
                    end
                end
                WAIT_EDGE: begin
                    if (fall) begin
                        sample_cnt <= '0;
                        to_cnt     <= '0;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                SAMPLE: begin
                    sample_cnt <= sample_cnt + CNT_W'(1);
                    if (sample_hit) begin
                        if ((PARITY_EN != 0) && (bit_cnt == PAR_IDX)) parity <= sync;
                        else                                         ID     <= {ID[ID_W-2:0], sync};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                // A pass sets ID_vld even if the core acknowledges in the same cycle.
                CHECK:   if (!frame_bad) ID_vld <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
